mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one synchronous single-port memory (256-byte ROM/RAM style: registered read data, one-cycle read latency, CS/WE strobes) between two requesters. Typical use: port A is the 6502 core, port B a debug/DMA/loader engine. One access is issued per cycle. Read data is steered back to the port that issued the read. A per-port starvation counter bounds waiting time under locked or fixed-priority traffic.

## Interface
- ADDR_W, 8, address width of memory and both ports
- DATA_W, 8, data width
- STARVE_MAX, 15, consecutive wait cycles after which a requester is force-granted (1..2^CNT_W-1)

- clk  in  1  CPU clock; all state on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- req_a / req_b  in  1  access request, held until granted
- we_a / we_b  in  1  1 = write, 0 = read
- lock_a / lock_b  in  1  keep ownership for back-to-back accesses while asserted with req
- addr_a / addr_b  in  ADDR_W  access address
- wdata_a / wdata_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  access issued this cycle
- rvalid_a / rvalid_b  out  1  read data valid this cycle
- rdata_a / rdata_b  out  DATA_W  read data (meaningful only with rvalid)
- mem_ab  out  ADDR_W  memory address
- mem_di  out  DATA_W  memory write data
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_do  in  DATA_W  memory read data (registered in memory; may be Z when not selected)

## Operation
- States: IDLE, OWN_A, OWN_B (owner register). Reset forces IDLE, both starvation counters to 0, and the rvalid pipeline to 0.
- Arbitration runs every cycle on req_a/req_b, in priority order:
  1. A port whose starvation counter equals STARVE_MAX wins. If both are at STARVE_MAX, the one not last granted wins.
  2. Current owner with lock asserted and req high keeps the bus.
  3. Otherwise the base policy applies (see Configuration).
  4. No request: mem_cs=0, state goes to IDLE.
- Winner's addr/wdata/we are muxed combinationally onto mem_ab/mem_di/mem_we in the same cycle. In that cycle mem_cs=1 and gnt_x=1. At most one gnt is high.
- Next state is OWN_x for the winner. Losing requester's counter increments (saturating at STARVE_MAX). Granted or idle port's counter clears to 0.
- Read issued in cycle N: rvalid_x=1 in cycle N+1, rdata_x=mem_do. Owner tag and the read flag are registered at N. rdata of the other port is held at its last value.
- Writes produce no rvalid.
- A requester changing addr/we while req is high and ungranted is legal. The value sampled is the one present in the grant cycle.
- Locked owner whose request drops: lock is ignored that cycle and arbitration reverts to normal.

## Timing
- Grant: combinational from req in the same cycle; zero-wait when uncontended.
- Read latency: 1 cycle from gnt to rvalid. Full throughput: one access per cycle, reads and writes interleaved freely.
- Worst-case wait for a requesting port: STARVE_MAX+1 cycles.
- Reset while a read is in flight: the rvalid for that read is suppressed. Outputs go to gnt=0, rvalid=0, mem_cs=0, mem_we=0, mem_ab=0, mem_di=0, rdata=0 in the cycle after reset is sampled low.
- Simultaneous request at IDLE with equal counters: resolved by base policy.

## Configuration
- MEM_ARB_RR_EN defined: base policy is round-robin. The port not last granted wins a tie. "Last granted" resets to B, so A wins the first tie.
- Undefined: fixed priority, A over B. Starvation forcing still bounds B's wait.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE, OWN_A, OWN_B)
  - port-select constants PORT_A=0, PORT_B=1
  - CNT_W derived from STARVE_MAX
- Sub-module mem_arb_starve_cnt: saturating wait counter with inc/clr and an at-max flag. Instantiated once per port.
- Arbitration decision, mux and rvalid pipeline stay in the top module.

## Test plan
- Uncontended read: req_a=1, we_a=0, addr_a=8'h10 for one cycle (memory holds 8'hA9 at 8'h10) -> gnt_a=1 and mem_cs=1 that cycle; rvalid_a=1 with rdata_a=8'hA9 next cycle; rvalid_b stays 0.
- Contention: req_a and req_b high from IDLE.
  - Fixed priority: A granted every cycle while B waits; B is force-granted on cycle 16 (STARVE_MAX=15).
  - With MEM_ARB_RR_EN: grants alternate A, B, A, B.
- Lock: lock_a=1, req_a continuous, req_b high -> A holds the bus until B's counter reaches 15; then gnt_b for one cycle, then A resumes.
- Back-to-back interleave: A reads 8'h00, B writes 8'h55 to 8'h01, A reads 8'h01 on consecutive cycles -> rvalid_a in cycles 2 and 4 with the correct data; no rvalid_b.
- Reset mid-read: gnt_a read in cycle N, reset low in cycle N+1 -> rvalid_a=0 afterwards; all outputs 0; state IDLE.
- Idle: no requests for 10 cycles -> mem_cs=0 and counters stay 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   - arb_state_t : bus ownership state (IDLE, OWN_A, OWN_B)
//   - PORT_A/B    : encoding used for the "last granted" register
//   - cnt_w()     : width of a counter able to hold 0..max
//   - CNT_W       : starvation counter width for the default STARVE_MAX
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int STARVE_MAX_DEF = 15;

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int CNT_W = cnt_w(STARVE_MAX_DEF);

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_cnt
// Saturating wait counter for one requester. Counts consecutive cycles in which
// the port requested but was not granted; sticks at MAX until cleared.
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset
//   i_inc      requester waited this cycle
//   i_clr      requester granted or idle this cycle (wins over i_inc)
//   o_at_max   counter has reached MAX
// -----------------------------------------------------------------------------
module mem_arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int W   = CNT_W,
   parameter int MAX = STARVE_MAX_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_max
);

   logic [W-1:0] r_cnt;
   logic         w_at_max;

   assign w_at_max = (r_cnt == W'(MAX));
   assign o_at_max = w_at_max;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_at_max) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous single-port memory (registered read data, one-cycle
// latency) between requesters A and B. One access per cycle; the grant is
// combinational from the requests. Read data is steered back to the issuing
// port one cycle after its grant. A per-port starvation counter force-grants
// a port that has waited STARVE_MAX consecutive cycles.
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// A has fixed priority over B.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req_x, i_we_x, i_lock_x      request, write enable, ownership lock
//   i_addr_x, i_wdata_x            access address / write data
//   o_gnt_x                        access issued this cycle
//   o_rvalid_x, o_rdata_x          read data return (held when not valid)
//   o_mem_ab/di/cs/we, i_mem_do    memory side
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_a,
   input  logic              i_req_b,
   input  logic              i_we_a,
   input  logic              i_we_b,
   input  logic              i_lock_a,
   input  logic              i_lock_b,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [DATA_W-1:0] i_wdata_a,
   input  logic [DATA_W-1:0] i_wdata_b,
   output logic              o_gnt_a,
   output logic              o_gnt_b,
   output logic              o_rvalid_a,
   output logic              o_rvalid_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b,
   output logic [ADDR_W-1:0] o_mem_ab,
   output logic [DATA_W-1:0] o_mem_di,
   output logic              o_mem_cs,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_do
);

   localparam int CW = cnt_w(STARVE_MAX);

   arb_state_t        r_state;
   arb_state_t        w_state_next;
   logic              r_last;
   logic              r_pend_a;
   logic              r_pend_b;
   logic [DATA_W-1:0] r_hold_a;
   logic [DATA_W-1:0] r_hold_b;

   logic              w_gnt_a;
   logic              w_gnt_b;
   logic              w_force_a;
   logic              w_force_b;
   logic              w_rvalid_a;
   logic              w_rvalid_b;
   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic [1:0]        w_inc;
   logic [1:0]        w_at_max;

   assign w_req = {i_req_b, i_req_a};
   assign w_gnt = {w_gnt_b, w_gnt_a};

   // One starvation counter per port: it counts while the port waits and
   // clears whenever the port is granted or not requesting.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_cnt
      assign w_inc[gi] = w_req[gi] & ~w_gnt[gi];

      mem_arb_starve_cnt #(
         .W   (CW),
         .MAX (STARVE_MAX)
      ) u_cnt (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_inc    (w_inc[gi]),
         .i_clr    (~w_inc[gi]),
         .o_at_max (w_at_max[gi])
      );
   end

   // A counter only reaches max while its port keeps requesting, but gate
   // with req anyway so a dropped request can never be force-granted.
   assign w_force_a = i_req_a & w_at_max[0];
   assign w_force_b = i_req_b & w_at_max[1];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Arbitration: starvation forcing, then lock hold, then base policy.
   // No access is issued while reset is asserted.
   always_comb begin
      w_gnt_a      = 1'b0;
      w_gnt_b      = 1'b0;
      w_state_next = IDLE;
      if (i_rst_n) begin
         if (w_force_a && w_force_b) begin
            if (r_last == PORT_A) w_gnt_b = 1'b1;
            else                  w_gnt_a = 1'b1;
         end else if (w_force_a) begin
            w_gnt_a = 1'b1;
         end else if (w_force_b) begin
            w_gnt_b = 1'b1;
         end else if (r_state == OWN_A && i_lock_a && i_req_a) begin
            w_gnt_a = 1'b1;
         end else if (r_state == OWN_B && i_lock_b && i_req_b) begin
            w_gnt_b = 1'b1;
         end else if (i_req_a && i_req_b) begin
`ifdef MEM_ARB_RR_EN
            if (r_last == PORT_A) w_gnt_b = 1'b1;
            else                  w_gnt_a = 1'b1;
`else
            w_gnt_a = 1'b1;
`endif
         end else if (i_req_a) begin
            w_gnt_a = 1'b1;
         end else if (i_req_b) begin
            w_gnt_b = 1'b1;
         end
      end
      if (w_gnt_a)      w_state_next = OWN_A;
      else if (w_gnt_b) w_state_next = OWN_B;
   end

   assign o_gnt_a  = w_gnt_a;
   assign o_gnt_b  = w_gnt_b;
   assign o_mem_cs = w_gnt_a | w_gnt_b;
   assign o_mem_we = w_gnt_a ? i_we_a    : (w_gnt_b ? i_we_b    : 1'b0);
   assign o_mem_ab = w_gnt_a ? i_addr_a  : (w_gnt_b ? i_addr_b  : '0);
   assign o_mem_di = w_gnt_a ? i_wdata_a : (w_gnt_b ? i_wdata_b : '0);

   // Read-return pipeline: the owner tag and read flag are captured at grant;
   // the memory's own output register supplies the data one cycle later.
   // Gating with i_rst_n drops a return that lands on a reset cycle.
   assign w_rvalid_a = r_pend_a & i_rst_n;
   assign w_rvalid_b = r_pend_b & i_rst_n;
   assign o_rvalid_a = w_rvalid_a;
   assign o_rvalid_b = w_rvalid_b;
   assign o_rdata_a  = w_rvalid_a ? i_mem_do : r_hold_a;
   assign o_rdata_b  = w_rvalid_b ? i_mem_do : r_hold_b;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last   <= PORT_B;
         r_pend_a <= 1'b0;
         r_pend_b <= 1'b0;
         r_hold_a <= '0;
         r_hold_b <= '0;
      end else begin
         if (w_gnt_a)      r_last <= PORT_A;
         else if (w_gnt_b) r_last <= PORT_B;
         r_pend_a <= w_gnt_a & ~i_we_a;
         r_pend_b <= w_gnt_b & ~i_we_b;
         if (r_pend_a) r_hold_a <= i_mem_do;
         if (r_pend_b) r_hold_b <= i_mem_do;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a 256-byte registered-read memory
// and a transaction-level reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int SM = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
   logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b, mem_cs, mem_we;
   logic [7:0] rdata_a, rdata_b, mem_ab, mem_di;
   wire  [7:0] mem_do;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_a    (req_a),
      .i_req_b    (req_b),
      .i_we_a     (we_a),
      .i_we_b     (we_b),
      .i_lock_a   (lock_a),
      .i_lock_b   (lock_b),
      .i_addr_a   (addr_a),
      .i_addr_b   (addr_b),
      .i_wdata_a  (wdata_a),
      .i_wdata_b  (wdata_b),
      .o_gnt_a    (gnt_a),
      .o_gnt_b    (gnt_b),
      .o_rvalid_a (rvalid_a),
      .o_rvalid_b (rvalid_b),
      .o_rdata_a  (rdata_a),
      .o_rdata_b  (rdata_b),
      .o_mem_ab   (mem_ab),
      .o_mem_di   (mem_di),
      .o_mem_cs   (mem_cs),
      .o_mem_we   (mem_we),
      .i_mem_do   (mem_do)
   );

   // Memory under arbitration: registered read, output floats when unselected.
   logic [7:0] mem [256];
   logic [7:0] mem_q;
   logic       mem_sel = 1'b0;
   always @(posedge clk) begin
      if (mem_cs && !mem_we) mem_q <= mem[mem_ab];
      if (mem_cs && mem_we)  mem[mem_ab] <= mem_di;
      mem_sel <= mem_cs && !mem_we;
   end
   assign mem_do = mem_sel ? mem_q : 8'bz;

   // Reference model state (owner/last: 0 none, 1 A, 2 B)
   int         m_cnt_a = 0, m_cnt_b = 0, m_owner = 0, m_last = 2;
   bit         m_pend_a = 0, m_pend_b = 0;
   logic [7:0] m_pend_data = 8'h00, m_hold_a = 8'h00, m_hold_b = 8'h00;
   logic [7:0] ref_mem [256];

   int         e_win;
   bit         e_we, e_rv_a, e_rv_b;
   logic [7:0] e_ab, e_di, e_rd_a, e_rd_b;

   int         checks = 0;
   int         fails  = 0;

   wire [37:0] act = {gnt_a, gnt_b, mem_cs, mem_we, mem_ab, mem_di,
                      rvalid_a, rvalid_b, rdata_a, rdata_b};

   function automatic int pick();
      bit fa, fb;
      if (!rst_n) return 0;
      fa = req_a && (m_cnt_a == SM);
      fb = req_b && (m_cnt_b == SM);
      if (fa && fb) return (m_last == 1) ? 2 : 1;
      if (fa) return 1;
      if (fb) return 2;
      if (m_owner == 1 && lock_a && req_a) return 1;
      if (m_owner == 2 && lock_b && req_b) return 2;
      if (req_a && req_b) begin
`ifdef MEM_ARB_RR_EN
         return (m_last == 1) ? 2 : 1;
`else
         return 1;
`endif
      end
      if (req_a) return 1;
      if (req_b) return 2;
      return 0;
   endfunction

   function automatic logic [37:0] exp_vec();
      return {e_win == 1, e_win == 2, e_win != 0, e_we, e_ab, e_di,
              e_rv_a, e_rv_b, e_rd_a, e_rd_b};
   endfunction

   task automatic model_comb();
      e_win  = pick();
      e_ab   = (e_win == 1) ? addr_a  : (e_win == 2) ? addr_b  : 8'h00;
      e_di   = (e_win == 1) ? wdata_a : (e_win == 2) ? wdata_b : 8'h00;
      e_we   = (e_win == 1) ? we_a    : (e_win == 2) ? we_b    : 1'b0;
      e_rv_a = m_pend_a && rst_n;
      e_rv_b = m_pend_b && rst_n;
      e_rd_a = e_rv_a ? m_pend_data : m_hold_a;
      e_rd_b = e_rv_b ? m_pend_data : m_hold_b;
   endtask

   task automatic model_commit();
      if (!rst_n) begin
         m_cnt_a = 0; m_cnt_b = 0; m_owner = 0; m_last = 2;
         m_pend_a = 0; m_pend_b = 0; m_hold_a = 8'h00; m_hold_b = 8'h00;
      end else begin
         if (m_pend_a) m_hold_a = m_pend_data;
         if (m_pend_b) m_hold_b = m_pend_data;
         m_pend_a = (e_win == 1) && !e_we;
         m_pend_b = (e_win == 2) && !e_we;
         if (e_win != 0 && !e_we) m_pend_data = ref_mem[e_ab];
         if (e_win != 0 && e_we)  ref_mem[e_ab] = e_di;
         m_cnt_a = (req_a && e_win != 1) ? ((m_cnt_a < SM) ? m_cnt_a + 1 : SM) : 0;
         m_cnt_b = (req_b && e_win != 2) ? ((m_cnt_b < SM) ? m_cnt_b + 1 : SM) : 0;
         m_owner = e_win;
         if (e_win != 0) m_last = e_win;
      end
   endtask

   // Inputs are driven at posedge+1; mid() moves to the falling edge to sample.
   task automatic mid();
      model_comb();
      #4;
   endtask

   task automatic next();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle_inputs();
      req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0; idle_inputs();
      mid(); next();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; req_a = 1; req_b = 1; we_a = 1; addr_a = 8'h33; wdata_a = 8'hC3;
      mid();
      checks++;
      if (act !== 38'd0) begin
         fails++; $display("FAIL reset_outputs: got %h expected %h", act, 38'd0);
      end
      $display("test_reset: outputs %h during reset", act);
      next();
      idle_inputs(); rst_n = 1;
   endtask

   task automatic test_uncontended_read();
      req_a = 1; we_a = 0; addr_a = 8'h10;
      mid();
      checks++;
      if ({gnt_a, gnt_b, mem_cs, mem_ab} !== {1'b1, 1'b0, 1'b1, 8'h10}) begin
         fails++; $display("FAIL unc_grant: got gnt_a=%b gnt_b=%b cs=%b ab=%h expected 1 0 1 10",
                           gnt_a, gnt_b, mem_cs, mem_ab);
      end
      next();
      req_a = 0;
      mid();
      checks++;
      if ({rvalid_a, rvalid_b, rdata_a} !== {1'b1, 1'b0, 8'hA9}) begin
         fails++; $display("FAIL unc_rdata: got rvalid_a=%b rvalid_b=%b rdata_a=%h expected 1 0 a9",
                           rvalid_a, rvalid_b, rdata_a);
      end
      $display("test_uncontended_read: rdata_a=%h rvalid_a=%b", rdata_a, rvalid_a);
      next();
   endtask

   task automatic test_contention();
      int first_b = 0;
      apply_reset();
      req_a = 1; req_b = 1; we_a = 0; we_b = 0;
      for (int c = 1; c <= 20; c++) begin
         addr_a = 8'($urandom); addr_b = 8'($urandom);
         mid();
         checks++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL contention_c%0d: got %h expected %h", c, act, exp_vec());
         end
         if (gnt_b && first_b == 0) first_b = c;
         next();
      end
      idle_inputs();
      mid();
      checks++;
      if (act !== exp_vec()) begin
         fails++; $display("FAIL contention_drain: got %h expected %h", act, exp_vec());
      end
      next();
      checks++;
`ifdef MEM_ARB_RR_EN
      if (first_b != 2) begin
         fails++; $display("FAIL contention_first_b: got cycle %0d expected 2", first_b);
      end
`else
      if (first_b != SM + 1) begin
         fails++; $display("FAIL contention_first_b: got cycle %0d expected %0d", first_b, SM + 1);
      end
`endif
      $display("test_contention: first B grant at cycle %0d", first_b);
   endtask

   task automatic test_lock();
      int first_b = 0, nb = 0;
      bit a_at_17 = 0;
      apply_reset();
      req_a = 1; req_b = 1; lock_a = 1; we_a = 0; we_b = 0;
      for (int c = 1; c <= 35; c++) begin
         addr_a = 8'($urandom); addr_b = 8'($urandom);
         mid();
         checks++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL lock_c%0d: got %h expected %h", c, act, exp_vec());
         end
         if (gnt_b) begin nb++; if (first_b == 0) first_b = c; end
         if (c == SM + 2) a_at_17 = gnt_a;
         next();
      end
      idle_inputs();
      mid(); next();
      checks++;
      if (first_b != SM + 1 || nb != 2 || !a_at_17) begin
         fails++; $display("FAIL lock_pattern: got first_b=%0d nb=%0d a_resume=%b expected %0d 2 1",
                           first_b, nb, a_at_17, SM + 1);
      end
      $display("test_lock: first_b=%0d b_grants=%0d", first_b, nb);
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      req_a = 1; we_a = 0; addr_a = 8'h00;
      mid();
      checks++;
      if (gnt_a !== 1'b1) begin fails++; $display("FAIL b2b_c1: got gnt_a=%b expected 1", gnt_a); end
      next();
      req_a = 0; req_b = 1; we_b = 1; addr_b = 8'h01; wdata_b = 8'h55;
      mid();
      checks++;
      if ({gnt_b, mem_we, mem_di, rvalid_a, rvalid_b, rdata_a} !== {1'b1, 1'b1, 8'h55, 1'b1, 1'b0, e_rd_a}) begin
         fails++; $display("FAIL b2b_c2: got gnt_b=%b we=%b di=%h rv_a=%b rv_b=%b rd_a=%h expected 1 1 55 1 0 %h",
                           gnt_b, mem_we, mem_di, rvalid_a, rvalid_b, rdata_a, e_rd_a);
      end
      next();
      req_b = 0; we_b = 0; req_a = 1; we_a = 0; addr_a = 8'h01;
      mid();
      checks++;
      if ({gnt_a, rvalid_a, rvalid_b} !== 3'b100) begin
         fails++; $display("FAIL b2b_c3: got gnt_a=%b rv_a=%b rv_b=%b expected 1 0 0", gnt_a, rvalid_a, rvalid_b);
      end
      next();
      req_a = 0;
      mid();
      checks++;
      if ({rvalid_a, rvalid_b, rdata_a} !== {1'b1, 1'b0, 8'h55}) begin
         fails++; $display("FAIL b2b_c4: got rv_a=%b rv_b=%b rd_a=%h expected 1 0 55", rvalid_a, rvalid_b, rdata_a);
      end
      $display("test_back_to_back: final rdata_a=%h", rdata_a);
      next();
   endtask

   task automatic test_reset_mid_read();
      idle_inputs();
      req_a = 1; we_a = 0; addr_a = 8'h10;
      mid(); next();
      req_a = 0; rst_n = 0;
      mid();
      checks++;
      if (rvalid_a !== 1'b0 || act !== exp_vec()) begin
         fails++; $display("FAIL rst_mid_read_n1: got %h expected %h", act, exp_vec());
      end
      next();
      rst_n = 1;
      mid();
      checks++;
      if (act !== 38'd0) begin
         fails++; $display("FAIL rst_mid_read_n2: got %h expected %h", act, 38'd0);
      end
      $display("test_reset_mid_read: outputs %h after reset", act);
      next();
   endtask

   task automatic test_random();
      bit hold_a = 0, hold_b = 0;
      int wa = 0, wb = 0, max_wait = 0;
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         if (!rst_n) begin hold_a = 0; hold_b = 0; end
         req_a   = hold_a ? 1'b1 : ($urandom_range(0, 9) < 6);
         req_b   = hold_b ? 1'b1 : ($urandom_range(0, 9) < 6);
         we_a    = 1'($urandom); we_b = 1'($urandom);
         lock_a  = ($urandom_range(0, 9) < 3); lock_b = ($urandom_range(0, 9) < 3);
         addr_a  = 8'($urandom_range(0, 15)); addr_b = 8'($urandom_range(0, 15));
         wdata_a = 8'($urandom); wdata_b = 8'($urandom);
         mid();
         checks++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL random_c%0d: got %h expected %h", c, act, exp_vec());
         end
         wa = (req_a && !gnt_a && rst_n) ? wa + 1 : 0;
         wb = (req_b && !gnt_b && rst_n) ? wb + 1 : 0;
         if (wa > max_wait) max_wait = wa;
         if (wb > max_wait) max_wait = wb;
         hold_a = req_a && !gnt_a && rst_n;
         hold_b = req_b && !gnt_b && rst_n;
         next();
      end
      rst_n = 1;
      checks++;
      if (max_wait > SM) begin
         fails++; $display("FAIL random_max_wait: got %0d expected <= %0d", max_wait, SM);
      end
      $display("test_random: 400 cycles, longest wait %0d", max_wait);
   endtask

   task automatic test_idle();
      idle_inputs();
      req_a = 1; req_b = 1; we_a = 0; we_b = 0;
      for (int c = 0; c < 3; c++) begin mid(); next(); end
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         mid();
         checks++;
         if (mem_cs !== 1'b0 || act !== exp_vec()) begin
            fails++; $display("FAIL idle_c%0d: got %h expected %h", c, act, exp_vec());
         end
         next();
      end
      checks++;
      if (dut.g_cnt[0].u_cnt.r_cnt !== '0 || dut.g_cnt[1].u_cnt.r_cnt !== '0) begin
         fails++; $display("FAIL idle_counters: got a=%0d b=%0d expected 0 0",
                           dut.g_cnt[0].u_cnt.r_cnt, dut.g_cnt[1].u_cnt.r_cnt);
      end
      $display("test_idle: mem_cs=%b after 10 idle cycles", mem_cs);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i * 37 + 5);
         ref_mem[i] = 8'(i * 37 + 5);
      end
      mem[8'h10]     = 8'hA9;
      ref_mem[8'h10] = 8'hA9;
      addr_a = 8'h00; addr_b = 8'h00; wdata_a = 8'h00; wdata_b = 8'h00;
      rst_n = 0; idle_inputs();
      #1;
      mid(); next();

      test_reset();
      test_uncontended_read();
      test_contention();
      test_lock();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      test_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
